pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: owns the privileged control registers,
// arbitrates stall/flush per cycle and produces the redirect PC on flushes.
module pipe_ctrl #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              LDHazard,
    input  logic              MemBusy,
    input  logic              MEMEn,
    input  logic [PC_W-1:0]   MEMPC,
    input  logic [2:0]        MEMExpCode,
    input  logic [1:0]        MEMCtrlOp,
    input  logic [4:0]        MEMDstAddr,
    input  logic [DATA_W-1:0] MEMOut,
    input  logic [7:0]        Irq,
    input  logic [4:0]        CRegRdAddr,
    output logic [DATA_W-1:0] CRegRdData,
    output logic              ExeMode,
    output logic              IntDetect,
    output logic              IFStall,
    output logic              IDStall,
    output logic              EXStall,
    output logic              MEMStall,
    output logic              IFFlush,
    output logic              IDFlush,
    output logic              EXFlush,
    output logic              MEMFlush,
    output logic [PC_W-1:0]   NewPC
);

    localparam logic [1:0] OP_WRCR = 2'd1;
    localparam logic [1:0] OP_EXRT = 2'd2;

    localparam logic [2:0] ACT_NONE = 3'd0;
    localparam logic [2:0] ACT_BUSY = 3'd1;
    localparam logic [2:0] ACT_EXC  = 3'd2;
    localparam logic [2:0] ACT_EXRT = 3'd3;
    localparam logic [2:0] ACT_WRCR = 3'd4;
    localparam logic [2:0] ACT_LDH  = 3'd5;

    localparam logic [2:0] CODE_IRQ = 3'd1;

    logic            prev_ie;
    logic            prev_mode;
    logic            ie;
    logic            mode;
    logic [7:0]      int_mask;
    logic [2:0]      exp_code;
    logic [PC_W-1:0] epc;
    logic [PC_W-1:0] exp_vector;

    logic            int_detect;
    logic [2:0]      eff_code;
    logic [2:0]      act;
    logic            unused_memout;

    assign unused_memout = ^MEMOut[DATA_W-1:PC_W];

    function automatic logic [DATA_W-1:0] cr_read(
        input logic [4:0]      idx,
        input logic [3:0]      status,
        input logic [7:0]      mask,
        input logic [2:0]      code,
        input logic [PC_W-1:0] pc_epc,
        input logic [PC_W-1:0] pc_vec
    );
        logic [DATA_W-1:0] val;
        val = '0;
        case (idx)
            5'd0:    val = DATA_W'(status);
            5'd1:    val = DATA_W'(mask);
            5'd2:    val = DATA_W'(code);
            5'd3:    val = DATA_W'({pc_epc, 2'b00});
            5'd4:    val = DATA_W'({pc_vec, 2'b00});
            default: val = '0;
        endcase
        return val;
    endfunction

    assign CRegRdData = cr_read(CRegRdAddr, {prev_ie, prev_mode, ie, mode},
                                int_mask, exp_code, epc, exp_vector);
    assign ExeMode    = mode;
    assign int_detect = ie & (|(Irq & ~int_mask));
    assign IntDetect  = int_detect;

    // An interrupt outranks any synchronous exception carried by the MEM instruction.
    always_comb begin
        eff_code = 3'd0;
        if (MEMEn) begin
            eff_code = int_detect ? CODE_IRQ : MEMExpCode;
        end
    end

    // Work held off by MemBusy simply waits: it is re-evaluated when the bus frees up.
    always_comb begin
        act = ACT_NONE;
        if (MemBusy) begin
            act = ACT_BUSY;
        end else if (eff_code != 3'd0) begin
            act = ACT_EXC;
        end else if (MEMEn && MEMCtrlOp == OP_EXRT) begin
            act = ACT_EXRT;
        end else if (MEMEn && MEMCtrlOp == OP_WRCR) begin
            act = ACT_WRCR;
        end else if (LDHazard) begin
            act = ACT_LDH;
        end
    end

    always_comb begin
        {IFStall, IDStall, EXStall, MEMStall} = 4'b0000;
        {IFFlush, IDFlush, EXFlush, MEMFlush} = 4'b0000;
        NewPC = '0;
        case (act)
            ACT_BUSY: begin
                {IFStall, IDStall, EXStall, MEMStall} = 4'b1111;
            end
            ACT_EXC: begin
                {IFFlush, IDFlush, EXFlush, MEMFlush} = 4'b1111;
                NewPC = exp_vector;
            end
            ACT_EXRT: begin
                {IFFlush, IDFlush, EXFlush, MEMFlush} = 4'b1111;
                NewPC = epc;
            end
            ACT_WRCR: begin
                {IFFlush, IDFlush, EXFlush, MEMFlush} = 4'b1111;
                NewPC = MEMPC + PC_W'(1);
            end
            ACT_LDH: begin
                {IFStall, IDStall} = 2'b11;
                EXFlush = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_ie    <= 1'b0;
            prev_mode  <= 1'b0;
            ie         <= 1'b0;
            mode       <= 1'b0;
            int_mask   <= 8'hFF;
            exp_code   <= 3'd0;
            epc        <= '0;
            exp_vector <= '0;
        end else begin
            case (act)
                ACT_EXC: begin
                    epc       <= MEMPC;
                    exp_code  <= eff_code;
                    prev_ie   <= ie;
                    prev_mode <= mode;
                    ie        <= 1'b0;
                    mode      <= 1'b0;
                end
                ACT_EXRT: begin
                    ie   <= prev_ie;
                    mode <= prev_mode;
                end
                ACT_WRCR: begin
                    case (MEMDstAddr)
                        5'd0:    {prev_ie, prev_mode, ie, mode} <= MEMOut[3:0];
                        5'd1:    int_mask   <= MEMOut[7:0];
                        5'd2:    exp_code   <= MEMOut[2:0];
                        5'd3:    epc        <= MEMOut[PC_W-1:0];
                        5'd4:    exp_vector <= MEMOut[PC_W-1:0];
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic,
// expected responses come from a register-array reference model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        LDHazard, MemBusy, MEMEn;
    logic [29:0] MEMPC;
    logic [2:0]  MEMExpCode;
    logic [1:0]  MEMCtrlOp;
    logic [4:0]  MEMDstAddr;
    logic [31:0] MEMOut;
    logic [7:0]  Irq;
    logic [4:0]  CRegRdAddr;
    logic [31:0] CRegRdData;
    logic        ExeMode, IntDetect;
    logic        IFStall, IDStall, EXStall, MEMStall;
    logic        IFFlush, IDFlush, EXFlush, MEMFlush;
    logic [29:0] NewPC;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .reset(reset), .LDHazard(LDHazard), .MemBusy(MemBusy),
        .MEMEn(MEMEn), .MEMPC(MEMPC), .MEMExpCode(MEMExpCode),
        .MEMCtrlOp(MEMCtrlOp), .MEMDstAddr(MEMDstAddr), .MEMOut(MEMOut),
        .Irq(Irq), .CRegRdAddr(CRegRdAddr), .CRegRdData(CRegRdData),
        .ExeMode(ExeMode), .IntDetect(IntDetect),
        .IFStall(IFStall), .IDStall(IDStall), .EXStall(EXStall), .MEMStall(MEMStall),
        .IFFlush(IFFlush), .IDFlush(IDFlush), .EXFlush(EXFlush), .MEMFlush(MEMFlush),
        .NewPC(NewPC)
    );

    typedef struct {
        logic [31:0] rd;
        logic        exe_mode;
        logic        int_det;
        logic [3:0]  stall;
        logic [3:0]  flush;
        logic [29:0] newpc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: CR0..CR4 stored as plain values, each clipped to its width.
    bit [31:0] cr [5];
    bit [31:0] width_mask [5];

    function automatic void model_reset();
        cr[0] = 32'h0;
        cr[1] = 32'hFF;
        cr[2] = 32'h0;
        cr[3] = 32'h0;
        cr[4] = 32'h0;
    endfunction

    function automatic void model_step(output exp_t e);
        bit [31:0] st;
        bit        intd;
        int        code;
        int        idx;
        int        dst;
        if (reset) model_reset();
        st  = cr[0];
        idx = int'(CRegRdAddr);
        if (idx > 4)       e.rd = 32'h0;
        else if (idx >= 3) e.rd = cr[idx] << 2;
        else               e.rd = cr[idx];
        e.exe_mode = st[0];
        intd       = st[1] && ((Irq & ~cr[1][7:0]) != 8'h0);
        e.int_det  = intd;
        code       = !MEMEn ? 0 : (intd ? 1 : int'(MEMExpCode));
        e.stall    = 4'b0000;
        e.flush    = 4'b0000;
        e.newpc    = 30'h0;
        if (MemBusy) begin
            e.stall = 4'b1111;
        end else if (code != 0) begin
            e.flush = 4'b1111;
            e.newpc = cr[4][29:0];
            if (!reset) begin
                cr[3] = 32'(MEMPC);
                cr[2] = 32'(code);
                cr[0] = (st & 32'h3) << 2;
            end
        end else if (MEMEn && MEMCtrlOp == 2'd2) begin
            e.flush = 4'b1111;
            e.newpc = cr[3][29:0];
            if (!reset) cr[0] = (st & 32'hC) | (st >> 2);
        end else if (MEMEn && MEMCtrlOp == 2'd1) begin
            e.flush = 4'b1111;
            e.newpc = MEMPC + 30'd1;
            dst = int'(MEMDstAddr);
            if (!reset && dst < 5) cr[dst] = MEMOut & width_mask[dst];
        end else if (LDHazard) begin
            e.stall = 4'b1100;
            e.flush = 4'b0010;
        end
    endfunction

    task automatic cyc(input bit rst_i, input bit ldh, input bit busy, input bit en,
                       input bit [29:0] pc, input bit [2:0] ec, input bit [1:0] op,
                       input bit [4:0] dst, input bit [31:0] dout, input bit [7:0] irq,
                       input bit [4:0] rda);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst_i; LDHazard = ldh; MemBusy = busy; MEMEn = en; MEMPC = pc;
        MEMExpCode = ec; MEMCtrlOp = op; MEMDstAddr = dst; MEMOut = dout;
        Irq = irq; CRegRdAddr = rda;
        model_step(e);
        sb_q.push_back(e);
    endtask

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("CRegRdData", CRegRdData, e.rd);
            chk("ExeMode", 32'(ExeMode), 32'(e.exe_mode));
            chk("IntDetect", 32'(IntDetect), 32'(e.int_det));
            chk("Stall", 32'({IFStall, IDStall, EXStall, MEMStall}), 32'(e.stall));
            chk("Flush", 32'({IFFlush, IDFlush, EXFlush, MEMFlush}), 32'(e.flush));
            chk("NewPC", 32'(NewPC), 32'(e.newpc));
        end
    end

    initial begin
        width_mask[0] = 32'hF;
        width_mask[1] = 32'hFF;
        width_mask[2] = 32'h7;
        width_mask[3] = 32'h3FFF_FFFF;
        width_mask[4] = 32'h3FFF_FFFF;
        model_reset();
        reset = 1'b1; LDHazard = 1'b0; MemBusy = 1'b0; MEMEn = 1'b0; MEMPC = '0;
        MEMExpCode = '0; MEMCtrlOp = '0; MEMDstAddr = '0; MEMOut = '0;
        Irq = '0; CRegRdAddr = '0;

        // Reset values, including an exception presented while reset is held.
        cyc(1, 0, 0, 0, 30'h0, 3'd0, 2'd0, 5'd0, 32'h0, 8'h00, 5'd0);
        cyc(1, 0, 0, 0, 30'h0, 3'd0, 2'd0, 5'd0, 32'h0, 8'h00, 5'd1);
        cyc(1, 0, 0, 0, 30'h0, 3'd0, 2'd0, 5'd0, 32'h0, 8'h00, 5'd3);
        cyc(1, 0, 0, 1, 30'h9, 3'd2, 2'd0, 5'd0, 32'h0, 8'hFF, 5'd4);
        cyc(0, 0, 0, 0, 30'h0, 3'd0, 2'd0, 5'd0, 32'h0, 8'h00, 5'd2);

        // WRCR CR4 then read back; set STATUS and INT_MASK.
        cyc(0, 0, 0, 1, 30'h40, 3'd0, 2'd1, 5'd4, 32'h100, 8'h00, 5'd4);
        cyc(0, 0, 0, 0, 30'h0, 3'd0, 2'd0, 5'd0, 32'h0, 8'h00, 5'd4);
        cyc(0, 0, 0, 1, 30'h41, 3'd0, 2'd1, 5'd0, 32'h3, 8'h00, 5'd0);
        cyc(0, 0, 0, 1, 30'h42, 3'd0, 2'd1, 5'd1, 32'hFE, 8'h00, 5'd1);

        // Interrupt beats MEMExpCode=5, then EXRT restores user mode.
        cyc(0, 0, 0, 1, 30'h55, 3'd5, 2'd0, 5'd0, 32'h0, 8'h01, 5'd0);
        cyc(0, 0, 0, 0, 30'h0, 3'd0, 2'd0, 5'd0, 32'h0, 8'h00, 5'd2);
        cyc(0, 0, 0, 0, 30'h0, 3'd0, 2'd0, 5'd0, 32'h0, 8'h00, 5'd3);
        cyc(0, 0, 0, 0, 30'h0, 3'd0, 2'd0, 5'd0, 32'h0, 8'h00, 5'd0);
        cyc(0, 0, 0, 1, 30'h77, 3'd0, 2'd2, 5'd0, 32'h0, 8'h00, 5'd0);
        cyc(0, 0, 0, 0, 30'h0, 3'd0, 2'd0, 5'd0, 32'h0, 8'h00, 5'd0);

        // Load-use hazard, alone and under MemBusy.
        cyc(0, 1, 0, 0, 30'h0, 3'd0, 2'd0, 5'd0, 32'h0, 8'h00, 5'd0);
        cyc(0, 1, 1, 0, 30'h0, 3'd0, 2'd0, 5'd0, 32'h0, 8'h00, 5'd0);

        // Exception held across three busy cycles, then serviced.
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 1, 1, 30'h123, 3'd2, 2'd0, 5'd0, 32'h0, 8'h00, 5'd2);
        cyc(0, 0, 0, 1, 30'h123, 3'd2, 2'd0, 5'd0, 32'h0, 8'h00, 5'd2);
        cyc(0, 0, 0, 0, 30'h0, 3'd0, 2'd0, 5'd0, 32'h0, 8'h00, 5'd2);
        cyc(0, 0, 0, 0, 30'h0, 3'd0, 2'd0, 5'd0, 32'h0, 8'h00, 5'd3);

        // Ignored ops: CtrlOp=3 and a WRCR to an out-of-range index; PC wrap.
        cyc(0, 0, 0, 1, 30'h5, 3'd0, 2'd3, 5'd0, 32'hF, 8'h00, 5'd0);
        cyc(0, 0, 0, 1, 30'h3FFF_FFFF, 3'd0, 2'd1, 5'd9, 32'hF, 8'h00, 5'd9);
        cyc(0, 0, 0, 0, 30'h0, 3'd0, 2'd0, 5'd0, 32'h0, 8'h00, 5'd0);

        for (int n = 0; n < 600; n++) begin
            bit          r_rst, r_ldh, r_busy, r_en;
            bit [2:0]    r_ec;
            bit [7:0]    r_irq;
            bit [4:0]    r_rda;
            r_rst  = ($urandom_range(0, 59) == 0);
            r_ldh  = ($urandom_range(0, 3) == 0);
            r_busy = ($urandom_range(0, 4) == 0);
            r_en   = ($urandom_range(0, 9) < 7);
            r_ec   = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd0;
            r_irq  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            r_rda  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            cyc(r_rst, r_ldh, r_busy, r_en, 30'($urandom), r_ec, 2'($urandom),
                5'($urandom_range(0, 6)), $urandom, r_irq, r_rda);
        end
        cyc(0, 0, 0, 0, 30'h0, 3'd0, 2'd0, 5'd0, 32'h0, 8'h00, 5'd0);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
